fetch_ctrl: RTL

Fetch-stage sequencer for the redirecting five-stage pipeline. Drives the IF stage's `nextpc`/`pcenable` and the IF/ID and ID/EX pipeline-register enables and flushes. Arbitrates between sequential fetch, EX-stage taken branches, ID-stage jumps, load-use stalls and a syscall halt, using a small boot/run/halt state machine. Optional performance counters report cycle, stall and redirect counts.

---
 rtl/fetch_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the redirecting five-stage pipeline.
//
// A BOOT/RUN/HALT state machine arbitrates between sequential fetch, EX-stage
// taken branches, ID-stage jumps, load-use stalls and a syscall halt. Every
// control output is combinational from the current state and the same-cycle
// inputs, so the PC and the pipeline registers act on the decision at the
// same clock edge.
//
// Optional feature macro: FETCH_PERF_EN. When it is defined, cycle, stall and
// redirect counters are built. When it is not defined, the counter outputs
// are tied to zero and no counter flops exist.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   pc_in          in   current PC from IF
//   br_taken_ex    in   branch in EX resolved taken
//   br_target_ex   in   branch target from EX
//   jmp_id         in   unconditional jump decoded in ID
//   jmp_target_id  in   jump target from ID
//   load_use       in   load-use hazard detected in ID
//   halt_req       in   syscall-halt instruction in EX
//   go             in   resume pulse, only honoured in HALT
//   nextpc         out  next PC to IF
//   pcenable       out  PC write enable
//   ifid_en        out  IF/ID register enable
//   ifid_flush     out  clear IF/ID to a bubble
//   idex_flush     out  clear ID/EX to a bubble
//   halted         out  high while in HALT
//   cyc_cnt        out  RUN cycle count
//   stall_cnt      out  RUN/HALT cycles with the PC held
//   redir_cnt      out  branches and jumps acted on
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        br_taken_ex,
  input  logic [31:0] br_target_ex,
  input  logic        jmp_id,
  input  logic [31:0] jmp_target_id,
  input  logic        load_use,
  input  logic        halt_req,
  input  logic        go,
  output logic [31:0] nextpc,
  output logic        pcenable,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [31:0] cyc_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] redir_cnt
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_boot_cnt;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_in + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_BOOT;
      r_boot_cnt <= BOOT_INIT;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_BOOT && r_boot_cnt != 4'd0)
        r_boot_cnt <= r_boot_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    nextpc      = pc_in;
    pcenable    = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_BOOT: begin
        nextpc     = RESET_PC;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (r_boot_cnt == 4'd0)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (br_taken_ex) begin
          // A branch resolving in EX outranks a halt in EX: the halting
          // instruction is on the squashed wrong path.
          nextpc     = br_target_ex;
          pcenable   = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (halt_req) begin
          idex_flush  = 1'b1;
          w_state_nxt = S_HALT;
        end else if (jmp_id) begin
          nextpc     = jmp_target_id;
          pcenable   = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else begin
          nextpc   = w_pc_plus4;
          pcenable = 1'b1;
          ifid_en  = 1'b1;
        end
      end
      S_HALT: begin
        halted     = 1'b1;
        idex_flush = 1'b1;
        if (go)
          w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redir_cnt;
  logic        w_redir;
  logic        w_stall;

  // A jump only redirects when neither a branch nor a halt outranks it.
  assign w_redir = (r_state == S_RUN) && (br_taken_ex || (!halt_req && jmp_id));
  assign w_stall = (r_state == S_RUN || r_state == S_HALT) && !pcenable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cyc_cnt   <= 32'd0;
      r_stall_cnt <= 32'd0;
      r_redir_cnt <= 32'd0;
    end else begin
      if (r_state == S_RUN) r_cyc_cnt   <= r_cyc_cnt + 32'd1;
      if (w_stall)          r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redir)          r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign cyc_cnt   = r_cyc_cnt;
  assign stall_cnt = r_stall_cnt;
  assign redir_cnt = r_redir_cnt;
`else
  assign cyc_cnt   = 32'h0;
  assign stall_cnt = 32'h0;
  assign redir_cnt = 32'h0;
`endif

endmodule
